// File: rtl/comms_pkg.sv
// Shared types and helpers for the serial-receive datapath.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package comms_pkg;

  // Word assembler FSM: IDLE holds no partial word, COLLECT holds 1..N-1 characters.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_t;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; head entry driven combinationally from storage.
// Latency: a push becomes visible at the head on the cycle after it is written.
// Backpressure: push while full is refused unless a pop happens on the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] push_data_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] pop_data_out,
  output logic             full_out,
  output logic             empty_out
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW:0]      occ_q, occ_d;
  logic             do_push;
  logic             do_pop;

  assign empty_out    = (occ_q == '0);
  assign full_out     = (occ_q == (PW+1)'(DEPTH));
  assign pop_data_out = mem_q[rd_q];

  // A pop frees a slot on the same edge, so a full FIFO can still accept a push alongside it.
  always_comb begin
    do_pop  = pop_in & ~empty_out;
    do_push = push_in & (~full_out | do_pop);
    wr_d    = do_push ? wr_q + PW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + PW'(1) : rd_q;
    occ_d   = occ_q;
    if (do_push && !do_pop) begin
      occ_d = occ_q + (PW+1)'(1);
    end else if (do_pop && !do_push) begin
      occ_d = occ_q - (PW+1)'(1);
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Storage carries no reset; entries are only read while occupancy says they are valid.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data_in;
    end
  end

endmodule

// File: rtl/rx_word_assembler.sv
// Packs UART characters little-endian into words and queues them in a small FIFO.
// Latency: valid_out rises the cycle after the final character strobe (FIFO empty).
// Backpressure: ready_in pops the FIFO; a completed word is dropped (sticky overflow) when full with no pop.
module rx_word_assembler
  import comms_pkg::*;
#(
  parameter int DATA_SIZE      = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [DATA_SIZE-1:0]                data_in,
  input  logic                                new_data_in,
  output logic [DATA_SIZE*BYTES_PER_WORD-1:0] word_out,
  output logic                                valid_out,
  input  logic                                ready_in,
  output logic                                busy_out,
  output logic                                timeout_out,
  output logic                                overflow_out
);

  localparam int WW = DATA_SIZE * BYTES_PER_WORD;
  localparam int CW = width_of(BYTES_PER_WORD);
  localparam int TW = width_of(TIMEOUT_CYCLES);

  asm_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [WW-1:0] word_q, word_d;
  logic [WW-1:0] ins_word;
  logic          tmo_q, tmo_d;
  logic          ovf_q, ovf_d;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign valid_out    = ~fifo_empty;
  assign pop          = valid_out & ready_in;
  assign busy_out     = (state_q == COLLECT);
  assign timeout_out  = tmo_q;
  assign overflow_out = ovf_q;

  // Partial word with the incoming character dropped into the slot selected by the count.
  always_comb begin
    ins_word = word_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (int'(cnt_q) == k) begin
        ins_word[k*DATA_SIZE +: DATA_SIZE] = data_in;
      end
    end
  end

  // Assembly FSM: a character always beats a timeout landing on the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    word_d  = word_q;
    tmo_d   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (new_data_in) begin
          word_d = ins_word;
          if (BYTES_PER_WORD == 1) begin
            push = 1'b1;
          end else begin
            cnt_d   = CW'(1);
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (new_data_in) begin
          word_d = ins_word;
          tmr_d  = '0;
          if (cnt_q == CW'(BYTES_PER_WORD - 1)) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          tmr_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tmr_d   = '0;
      end
    endcase
  end

  // Overflow latches when a finished word meets a full FIFO that is not draining this cycle.
  always_comb begin
    ovf_d = ovf_q | (push & fifo_full & ~pop);
  end

  // Assembler state; reset discards any partial word without a timeout pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      tmo_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      tmo_q   <= tmo_d;
      ovf_q   <= ovf_d;
    end
  end

  // Partial word shift register; its contents are meaningless outside COLLECT.
  always_ff @(posedge clk_in) begin
    word_q <= word_d;
  end

  sync_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .push_in      (push),
    .push_data_in (ins_word),
    .pop_in       (pop),
    .pop_data_out (word_out),
    .full_out     (fifo_full),
    .empty_out    (fifo_empty)
  );

endmodule

// File: tb/tb_rx_word_assembler.sv
// Directed bench for rx_word_assembler: assembly, timeout edge, overflow, full push/pop, reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: ready_in driven per scenario.
module tb_rx_word_assembler;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  data_in;
  logic        new_data_in;
  logic [31:0] word_out;
  logic        valid_out;
  logic        ready_in;
  logic        busy_out;
  logic        timeout_out;
  logic        overflow_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wl [5];

  always #5 clk_in = ~clk_in;

  rx_word_assembler #(
    .DATA_SIZE      (8),
    .BYTES_PER_WORD (4),
    .TIMEOUT_CYCLES (20),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .data_in      (data_in),
    .new_data_in  (new_data_in),
    .word_out     (word_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .busy_out     (busy_out),
    .timeout_out  (timeout_out),
    .overflow_out (overflow_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_char(input logic [7:0] d);
    data_in     = d;
    new_data_in = 1'b1;
    @(posedge clk_in);
    #1;
    new_data_in = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_char(w[k*8 +: 8]);
  endtask

  task automatic pop_word(input string tag, input logic [31:0] w);
    check({tag, "_vld"}, {31'b0, valid_out}, 32'd1);
    check(tag, word_out, w);
    ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    ready_in = 1'b0;
  endtask

  initial begin
    wl[0] = 32'hA3A2A1A0;
    wl[1] = 32'hB3B2B1B0;
    wl[2] = 32'hC3C2C1C0;
    wl[3] = 32'hD3D2D1D0;
    wl[4] = 32'hE3E2E1E0;
    rst_in      = 1'b1;
    data_in     = 8'h00;
    new_data_in = 1'b0;
    ready_in    = 1'b0;
    cyc(2);
    rst_in = 1'b0;
    check("rst_valid", {31'b0, valid_out},    32'd0);
    check("rst_busy",  {31'b0, busy_out},     32'd0);
    check("rst_tmo",   {31'b0, timeout_out},  32'd0);
    check("rst_ovf",   {31'b0, overflow_out}, 32'd0);

    // Scenario 1: four characters with 10-cycle gaps, consumer always ready.
    ready_in = 1'b1;
    send_char(8'h11);
    check("s1_busy1",  {31'b0, busy_out},  32'd1);
    check("s1_valid1", {31'b0, valid_out}, 32'd0);
    cyc(10);
    send_char(8'h22);
    cyc(10);
    send_char(8'h33);
    check("s1_busy3",  {31'b0, busy_out},  32'd1);
    check("s1_valid3", {31'b0, valid_out}, 32'd0);
    cyc(10);
    send_char(8'h44);
    check("s1_valid4", {31'b0, valid_out}, 32'd1);
    check("s1_word",   word_out, 32'h44332211);
    check("s1_busy4",  {31'b0, busy_out},  32'd0);
    cyc(1);
    check("s1_popped", {31'b0, valid_out}, 32'd0);

    // Scenario 2: two characters then 20 idle cycles discards the partial word.
    send_char(8'hAA);
    send_char(8'hBB);
    cyc(19);
    check("s2_busy19", {31'b0, busy_out},    32'd1);
    check("s2_tmo19",  {31'b0, timeout_out}, 32'd0);
    cyc(1);
    check("s2_tmo20",  {31'b0, timeout_out}, 32'd1);
    check("s2_busy20", {31'b0, busy_out},    32'd0);
    check("s2_noword", {31'b0, valid_out},   32'd0);
    cyc(1);
    check("s2_tmo_end", {31'b0, timeout_out}, 32'd0);
    send_word(32'h04030201);
    check("s2_valid", {31'b0, valid_out}, 32'd1);
    check("s2_word",  word_out, 32'h04030201);
    cyc(1);

    // Scenario 6: each character arrives exactly when the timer would expire.
    send_char(8'hC1);
    cyc(19);
    send_char(8'hC2);
    check("s6_tmo",  {31'b0, timeout_out}, 32'd0);
    check("s6_busy", {31'b0, busy_out},    32'd1);
    cyc(19);
    send_char(8'hC3);
    cyc(19);
    send_char(8'hC4);
    check("s6_valid", {31'b0, valid_out}, 32'd1);
    check("s6_word",  word_out, 32'hC4C3C2C1);
    cyc(1);

    // Scenario 3: five words with no consumer; the fifth is dropped.
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) send_word(wl[i]);
    check("s3_ovf4", {31'b0, overflow_out}, 32'd0);
    send_word(wl[4]);
    check("s3_ovf5", {31'b0, overflow_out}, 32'd1);
    pop_word("s3_w1", wl[0]);
    pop_word("s3_w2", wl[1]);
    pop_word("s3_w3", wl[2]);
    pop_word("s3_w4", wl[3]);
    check("s3_empty",  {31'b0, valid_out},    32'd0);
    check("s3_sticky", {31'b0, overflow_out}, 32'd1);

    // Scenario 5: reset mid-word with two words queued and overflow set.
    send_word(wl[0]);
    send_word(wl[1]);
    send_char(8'h55);
    send_char(8'h66);
    send_char(8'h77);
    check("s5_busy_pre", {31'b0, busy_out}, 32'd1);
    rst_in = 1'b1;
    cyc(1);
    rst_in = 1'b0;
    check("s5_valid", {31'b0, valid_out},    32'd0);
    check("s5_busy",  {31'b0, busy_out},     32'd0);
    check("s5_ovf",   {31'b0, overflow_out}, 32'd0);
    check("s5_tmo",   {31'b0, timeout_out},  32'd0);
    cyc(1);
    check("s5_tmo2",  {31'b0, timeout_out},  32'd0);
    ready_in = 1'b1;
    send_word(32'hDEADBEEF);
    check("s5_word", word_out, 32'hDEADBEEF);
    cyc(1);
    ready_in = 1'b0;

    // Scenario 4: FIFO full, fifth word completes on the same cycle as a pop.
    for (int i = 0; i < 4; i++) send_word(wl[i]);
    send_char(wl[4][7:0]);
    send_char(wl[4][15:8]);
    send_char(wl[4][23:16]);
    data_in     = wl[4][31:24];
    new_data_in = 1'b1;
    ready_in    = 1'b1;
    @(posedge clk_in);
    #1;
    new_data_in = 1'b0;
    ready_in    = 1'b0;
    check("s4_ovf", {31'b0, overflow_out}, 32'd0);
    pop_word("s4_w2", wl[1]);
    pop_word("s4_w3", wl[2]);
    pop_word("s4_w4", wl[3]);
    pop_word("s4_w5", wl[4]);
    check("s4_empty", {31'b0, valid_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_word_assembler.md
RX_WORD_ASSEMBLER -- requirements
Module: rx_word_assembler

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: width of each received character from the UART receiver.
REQ-002 SHALL have parameter BYTES_PER_WORD, default 4: characters per assembled word, range 1..16.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle clock cycles tolerated between characters of one word, at least 1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, a power of 2, at least 2.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-007 rst_in  input  1  synchronous active-high reset.
REQ-008 data_in  input  DATA_SIZE  received character, sampled only when new_data_in=1.
REQ-009 new_data_in  input  1  single-cycle strobe from the UART receiver marking a valid data_in.
REQ-010 word_out  output  DATA_SIZE*BYTES_PER_WORD  head-of-FIFO word.
REQ-011 valid_out  output  1  FIFO non-empty; word_out is valid.
REQ-012 ready_in  input  1  consumer accepts word_out when valid_out=1 and ready_in=1.
REQ-013 busy_out  output  1  a partial word is being collected.
REQ-014 timeout_out  output  1  one-cycle pulse when a partial word is discarded.
REQ-015 overflow_out  output  1  sticky flag: a completed word was dropped because the FIFO was full.

Function
REQ-016 SHALL implement the FSM states IDLE (character count 0) and COLLECT (0 < count < BYTES_PER_WORD).
REQ-017 SHALL place character k (k=0 first) at word bits [k*DATA_SIZE +: DATA_SIZE], i.e. little-endian order.
REQ-018 IDLE + new_data_in: SHALL store character 0, set count=1, and go to COLLECT; if BYTES_PER_WORD=1 it SHALL instead push the word immediately and stay in IDLE.
REQ-019 COLLECT + new_data_in with count=BYTES_PER_WORD-1: SHALL push the completed word to the FIFO, clear count, and go to IDLE.
REQ-020 COLLECT + new_data_in otherwise: SHALL store the character, increment count, and clear the idle timer.
REQ-021 Idle timer: SHALL increment on each COLLECT cycle without new_data_in and SHALL be cleared in IDLE.
REQ-022 Timeout: when the timer reaches TIMEOUT_CYCLES, SHALL discard the partial word, pulse timeout_out for 1 cycle, clear count, and go to IDLE.
REQ-023 If new_data_in arrives on the cycle the timer would reach TIMEOUT_CYCLES, the character SHALL win: it is stored and no timeout occurs.
REQ-024 busy_out SHALL be 1 exactly while the FSM is in COLLECT.
REQ-025 Latency: valid_out SHALL assert on the cycle after the final character's strobe when the FIFO was empty.
REQ-026 word_out SHALL be show-ahead: the head entry is presented combinationally from FIFO storage.
REQ-027 Pop: SHALL occur on a cycle with valid_out=1 and ready_in=1; ready_in SHALL be ignored while valid_out=0.
REQ-028 Push with FIFO full and no pop on that cycle: SHALL drop the word, set overflow_out, and leave the FIFO contents unchanged.
REQ-029 Push and pop on the same cycle with FIFO full: SHALL accept both, keeping occupancy at FIFO_DEPTH, with no overflow.
REQ-030 Push and pop on the same cycle with FIFO empty: SHALL write the word; valid_out rises next cycle (no bypass).
REQ-031 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use log2(FIFO_DEPTH)+1 bits.
REQ-032 overflow_out SHALL stay set until rst_in.

Reset
REQ-033 rst_in=1 SHALL force: state IDLE, count 0, timer 0, FIFO empty, valid_out 0, busy_out 0, timeout_out 0, overflow_out 0.
REQ-034 Reset mid-word or with the FIFO non-empty SHALL discard all partial and stored words, with no timeout_out pulse.
REQ-035 word_out SHALL be don't-care while valid_out=0; FIFO storage SHALL need no reset.

Structure
REQ-036 The FSM state enum and a clog2-based width helper SHALL live in the shared package comms_pkg.
REQ-037 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and depth, exposing full/empty/push/pop.
REQ-038 The UART receiver's data_out and new_data_out outputs SHALL connect directly to data_in and new_data_in.

Verification
REQ-039 Scenario 1: ready_in=1, strobe 8'h11, 8'h22, 8'h33, 8'h44 with 10-cycle gaps -> word_out=32'h44332211 and valid_out on the cycle after the 4th strobe; busy_out high from the 1st strobe until the 4th.
REQ-040 Scenario 2: TIMEOUT_CYCLES=20; strobe 2 characters, then idle 20 cycles -> a single timeout_out pulse, busy_out falls, no word; the next 4 characters assemble correctly.
REQ-041 Scenario 3: ready_in=0; send 5 words (FIFO_DEPTH=4) -> overflow_out=1 after the 5th; popping yields words 1-4 in order, and the 5th is absent.
REQ-042 Scenario 4: FIFO full with ready_in=1 on the cycle a 5th word completes -> no overflow; occupancy stays 4; words are popped in order.
REQ-043 Scenario 5: assert rst_in after 3 characters with 2 words queued -> next cycle valid_out=0, busy_out=0, overflow_out=0; a subsequent word assembles from character 0.
REQ-044 Scenario 6: a strobe on exactly cycle TIMEOUT_CYCLES of idle -> no timeout; the word completes normally.
